// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types and constants for the data-memory responder.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dmem_state_t;

    // Clears the byte offset so every memory access is word aligned
    localparam word_t WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: M-stage request/response signals, memory bus signals and
// the snoop port. The slave modport is the responder's view, master the environment's.
interface dmem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              dmemREN;
    logic              dmemWEN;
    logic              datomic;
    logic [ADDR_W-1:0] dmemaddr;
    logic [DATA_W-1:0] dmemstore;
    logic              dhit;
    logic [DATA_W-1:0] dmemload;

    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic [DATA_W-1:0] dload;
    logic              dwait;

    logic              snoop_inv;
    logic [ADDR_W-1:0] snoop_addr;

    modport slave (
        input  dmemREN, dmemWEN, datomic, dmemaddr, dmemstore,
        output dhit, dmemload,
        output dREN, dWEN, daddr, dstore,
        input  dload, dwait,
        input  snoop_inv, snoop_addr
    );

    modport master (
        output dmemREN, dmemWEN, datomic, dmemaddr, dmemstore,
        input  dhit, dmemload,
        input  dREN, dWEN, daddr, dstore,
        output dload, dwait,
        output snoop_inv, snoop_addr
    );

endinterface

// File: rtl/ll_sc_link.sv
// ll_sc_link: load-linked reservation. Holds one word address that an SC may
// still succeed on, and drops it on SC, on a plain write to it, or on a snoop hit.
module ll_sc_link
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              wr_done,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              sc_done,
    input  logic              snoop_inv,
    input  logic [ADDR_W-1:0] snoop_addr,
    input  logic [ADDR_W-1:0] sc_addr,
    output logic              sc_ok
);

    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(WORD_MASK);

    logic              link_valid;
    logic [ADDR_W-1:0] link_addr;
    logic [ADDR_W-1:0] snoop_ref;
    logic              snoop_hit;
    logic              sc_snoop_hit;
    logic              wr_hit;

    // A snoop landing in the same cycle as an LL completion is compared against
    // the address being linked, so the snoop wins over the new reservation.
    assign snoop_ref    = set_en ? set_addr : link_addr;
    assign snoop_hit    = snoop_inv && ((snoop_addr & ADDR_MASK) == snoop_ref);
    assign sc_snoop_hit = snoop_inv && ((snoop_addr & ADDR_MASK) == link_addr);
    assign wr_hit       = wr_done && (wr_addr == link_addr);
    assign sc_ok        = link_valid && (sc_addr == link_addr) && !sc_snoop_hit;

    // Reservation register: any clearing event has priority over a new link
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else begin
            if (set_en) begin
                link_addr <= set_addr;
            end
            if (snoop_hit || wr_hit || sc_done) begin
                link_valid <= 1'b0;
            end else if (set_en) begin
                link_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: runs the M-stage load/store against the word-wide memory bus
// with wait states and returns a one-cycle dhit. Define DMEM_ATOMIC_EN to build
// LL/SC support (link register and snoop invalidation); otherwise SC is a plain store.
module dmem_responder
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    dmem_responder_if.slave       bus
);

    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(WORD_MASK);

    dmem_state_t       state_q;
    dmem_state_t       state_n;
    logic              accept;
    logic              sc_fail;
    logic              mem_done;
    logic              atomic_q;
    logic              atomic_in;
    logic              sc_req;
    logic              sc_ok;
    logic [ADDR_W-1:0] addr_in;
    logic [ADDR_W-1:0] daddr_q;
    logic [DATA_W-1:0] dstore_q;
    logic [DATA_W-1:0] dmemload_q;

    assign addr_in  = bus.dmemaddr & ADDR_MASK;
    assign mem_done = ((state_q == READ) || (state_q == WRITE)) && !bus.dwait;

`ifdef DMEM_ATOMIC_EN
    assign atomic_in = bus.datomic;
    assign sc_req    = bus.dmemWEN && bus.datomic;

    ll_sc_link #(.ADDR_W(ADDR_W)) u_link (
        .CLK        (CLK),
        .nRST       (nRST),
        .set_en     (mem_done && (state_q == READ) && atomic_q),
        .set_addr   (daddr_q),
        .wr_done    (mem_done && (state_q == WRITE) && !atomic_q),
        .wr_addr    (daddr_q),
        .sc_done    (sc_fail || (mem_done && (state_q == WRITE) && atomic_q)),
        .snoop_inv  (bus.snoop_inv),
        .snoop_addr (bus.snoop_addr),
        .sc_addr    (addr_in),
        .sc_ok      (sc_ok)
    );
`else
    logic unused_atomic;
    assign unused_atomic = ^{bus.datomic, bus.snoop_inv, bus.snoop_addr};
    assign atomic_in     = 1'b0;
    assign sc_req        = 1'b0;
    assign sc_ok         = 1'b1;
`endif

    // State register; reset aborts any access in flight
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state: write wins over read, a failed SC completes without memory
    always_comb begin
        state_n = state_q;
        accept  = 1'b0;
        sc_fail = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dmemWEN) begin
                    accept = 1'b1;
                    if (sc_req && !sc_ok) begin
                        sc_fail = 1'b1;
                        state_n = DONE;
                    end else begin
                        state_n = WRITE;
                    end
                end else if (bus.dmemREN) begin
                    accept  = 1'b1;
                    state_n = READ;
                end
            end
            READ:    if (!bus.dwait) state_n = DONE;
            WRITE:   if (!bus.dwait) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Request latch and bus/result registers; daddr and dstore only move when memory is used
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            atomic_q   <= 1'b0;
            daddr_q    <= '0;
            dstore_q   <= '0;
            dmemload_q <= '0;
        end else begin
            if (accept) begin
                atomic_q <= atomic_in;
            end
            if (accept && (state_n != DONE)) begin
                daddr_q <= addr_in;
            end
            if (accept && (state_n == WRITE)) begin
                dstore_q <= bus.dmemstore;
            end
            if (mem_done && (state_q == READ)) begin
                dmemload_q <= bus.dload;
            end else if (sc_fail) begin
                dmemload_q <= '0;
            end else if (mem_done && (state_q == WRITE) && atomic_q) begin
                dmemload_q <= DATA_W'(1);
            end
        end
    end

    assign bus.dhit     = (state_q == DONE);
    assign bus.dREN     = (state_q == READ);
    assign bus.dWEN     = (state_q == WRITE);
    assign bus.daddr    = daddr_q;
    assign bus.dstore   = dstore_q;
    assign bus.dmemload = dmemload_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized transactions checked against a
// transaction-level model of loads, stores, LL/SC reservations and snoops.
module tb_dmem_responder;

`ifdef DMEM_ATOMIC_EN
    localparam bit ATOMIC_ON = 1'b1;
`else
    localparam bit ATOMIC_ON = 1'b0;
`endif
    localparam int BUDGET = 20;

    logic CLK = 1'b0;
    logic nRST;

    int          nChecks = 0;
    int          nErrors = 0;
    bit          linkValid = 1'b0;
    logic [31:0] linkAddr = 32'h0;
    logic [31:0] modelLoad = 32'h0;

    dmem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_responder #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One datapath transaction, entered and left on a falling edge in IDLE.
    task automatic applyStimulus(input bit isRead, input bit isWrite, input bit atomic,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [31:0] loadVal, input int waits,
                                 input bit snoopEn, input logic [31:0] snoopAddr);
        logic [31:0] expAddr;
        bit          memTouch;
        int          expLat;
        int          lat;
        int          strobes;
        int          wrongStrobe;
        int          addrBad;
        int          storeBad;

        expAddr  = addr & 32'hFFFF_FFFC;
        memTouch = 1'b1;
        if (ATOMIC_ON && snoopEn && ((snoopAddr & 32'hFFFF_FFFC) == linkAddr)) linkValid = 1'b0;
        if (isWrite) begin
            if (ATOMIC_ON && atomic) begin
                if (linkValid && (linkAddr == expAddr)) begin
                    modelLoad = 32'd1;
                end else begin
                    memTouch  = 1'b0;
                    modelLoad = 32'd0;
                end
                linkValid = 1'b0;
            end else if (linkAddr == expAddr) begin
                linkValid = 1'b0;
            end
        end else begin
            modelLoad = loadVal;
            if (ATOMIC_ON && atomic) begin
                linkValid = 1'b1;
                linkAddr  = expAddr;
            end
        end
        expLat = memTouch ? waits + 2 : 1;

        bus.dmemREN    = isRead;
        bus.dmemWEN    = isWrite;
        bus.datomic    = atomic;
        bus.dmemaddr   = addr;
        bus.dmemstore  = data;
        bus.snoop_inv  = snoopEn;
        bus.snoop_addr = snoopAddr;
        lat = -1; strobes = 0; wrongStrobe = 0; addrBad = 0; storeBad = 0;
        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            if (bus.dhit === 1'b1) begin
                lat = cyc;
                break;
            end
            if (bus.dREN === 1'b1 || bus.dWEN === 1'b1) begin
                strobes++;
                if (isWrite ? bus.dREN : bus.dWEN) wrongStrobe++;
                if (bus.daddr !== expAddr) addrBad++;
                if (isWrite && bus.dstore !== data) storeBad++;
                bus.dwait = (strobes <= waits);
                bus.dload = (strobes <= waits) ? $urandom : loadVal;
            end else begin
                bus.dwait = 1'($urandom);
                bus.dload = $urandom;
            end
            if (cyc == 1) begin
                bus.dmemaddr  = $urandom;
                bus.dmemstore = $urandom;
                bus.datomic   = 1'($urandom);
            end
            @(posedge CLK);
            @(negedge CLK);
            bus.snoop_inv = 1'b0;
        end
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
        bus.datomic = 1'b0;
        checkOutput("latency", lat, expLat);
        checkOutput("strobe_cycles", strobes, memTouch ? waits + 1 : 0);
        checkOutput("strobe_kind", wrongStrobe, 0);
        checkOutput("daddr", addrBad, 0);
        checkOutput("dstore", storeBad, 0);
        checkOutput("dmemload", bus.dmemload, modelLoad);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic applySnoop(input logic [31:0] addr);
        if (ATOMIC_ON && ((addr & 32'hFFFF_FFFC) == linkAddr)) linkValid = 1'b0;
        bus.snoop_inv  = 1'b1;
        bus.snoop_addr = addr;
        @(posedge CLK);
        @(negedge CLK);
        bus.snoop_inv = 1'b0;
    endtask

    initial begin
        logic [31:0] pool [4];
        int          kind;
        int          dhitCount;
        pool = '{32'h300, 32'h304, 32'h104, 32'h000};

        nRST = 1'b0;
        bus.dmemREN = 1'b0; bus.dmemWEN = 1'b0; bus.datomic = 1'b0;
        bus.dmemaddr = '0; bus.dmemstore = '0; bus.dload = '0; bus.dwait = 1'b1;
        bus.snoop_inv = 1'b0; bus.snoop_addr = '0;
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("rst_dhit", bus.dhit, 0);
        checkOutput("rst_dREN", bus.dREN, 0);
        checkOutput("rst_dWEN", bus.dWEN, 0);
        checkOutput("rst_daddr", bus.daddr, 0);
        checkOutput("rst_dstore", bus.dstore, 0);
        checkOutput("rst_dmemload", bus.dmemload, 0);
        nRST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);

        applyStimulus(1, 0, 0, 32'h104, 32'h0, 32'hDEADBEEF, 2, 0, 0);
        applyStimulus(0, 1, 0, 32'h206, 32'hCAFEF00D, 32'h0, 0, 0, 0);
        applyStimulus(1, 0, 0, 32'h208, 32'h0, 32'h12345678, 1, 0, 0);
        applyStimulus(1, 1, 0, 32'h10C, 32'hA5A5A5A5, 32'h0BADF00D, 1, 0, 0);
        applyStimulus(1, 0, 1, 32'h300, 32'h0, 32'h11111111, 0, 0, 0);
        applyStimulus(0, 1, 1, 32'h300, 32'h22222222, 32'h0, 1, 0, 0);
        applyStimulus(0, 1, 1, 32'h300, 32'h33333333, 32'h0, 0, 0, 0);
        applyStimulus(1, 0, 1, 32'h300, 32'h0, 32'h44444444, 1, 0, 0);
        applySnoop(32'h302);
        applyStimulus(0, 1, 1, 32'h300, 32'h55555555, 32'h0, 0, 0, 0);
        applyStimulus(1, 0, 1, 32'h300, 32'h0, 32'h66666666, 0, 0, 0);
        applyStimulus(0, 1, 1, 32'h300, 32'h77777777, 32'h0, 0, 1, 32'h301);
        applyStimulus(1, 0, 1, 32'h300, 32'h0, 32'h88888888, 2, 0, 0);
        applyStimulus(0, 1, 0, 32'h300, 32'h99999999, 32'h0, 0, 0, 0);
        applyStimulus(0, 1, 1, 32'h300, 32'hAAAAAAAA, 32'h0, 0, 0, 0);
        applyStimulus(1, 0, 1, 32'h300, 32'h0, 32'hBBBBBBBB, 0, 0, 0);
        applyStimulus(0, 1, 0, 32'h304, 32'hCCCCCCCC, 32'h0, 1, 0, 0);
        applyStimulus(0, 1, 1, 32'h302, 32'hDDDDDDDD, 32'h0, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 4);
            if ($urandom_range(0, 4) == 0) applySnoop(pool[$urandom_range(0, 3)] | $urandom_range(0, 3));
            applyStimulus(kind == 0 || kind == 1 || kind == 4, kind >= 2, kind == 1 || kind == 3,
                          pool[$urandom_range(0, 3)] | $urandom_range(0, 3), $urandom, $urandom,
                          $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                          pool[$urandom_range(0, 3)] | $urandom_range(0, 3));
        end

        applyStimulus(1, 0, 1, 32'h300, 32'h0, 32'hFEEDFACE, 0, 0, 0);
        bus.dmemREN  = 1'b1;
        bus.dmemaddr = 32'h104;
        bus.dwait    = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("mid_dREN_before", bus.dREN, 1);
        #2 nRST = 1'b0;
        bus.dmemREN = 1'b0;
        #1 checkOutput("mid_dREN_async", bus.dREN, 0);
        linkValid = 1'b0; linkAddr = 32'h0; modelLoad = 32'h0;
        @(negedge CLK);
        nRST = 1'b1;
        dhitCount = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.dhit === 1'b1) dhitCount++;
            @(negedge CLK);
        end
        checkOutput("mid_no_dhit", dhitCount, 0);
        checkOutput("mid_dmemload", bus.dmemload, 0);
        applyStimulus(0, 1, 1, 32'h300, 32'h13572468, 32'h0, 0, 0, 0);
        applyStimulus(1, 0, 0, 32'h104, 32'h0, 32'h0F0F0F0F, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the datapath's M-stage port: it accepts the load/store/atomic request that the EX/M latch holds (`dmemREN`, `dmemWEN`, `datomic`, address, store data), runs it against the word-wide RAM/bus interface with wait states, and returns `dhit` plus load data. It sits between the M stage and the memory controller. It owns the LL/SC link register, so `dhit` is the only stall/advance signal the datapath sees for data accesses.

## Interface
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 32: word width; only 32 is supported.
- `CLK` in 1: single clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `dmemREN` in 1: datapath read request, held until `dhit`.
- `dmemWEN` in 1: datapath write request, held until `dhit`.
- `datomic` in 1: qualifies the request as LL (with REN) or SC (with WEN).
- `dmemaddr` in ADDR_W: byte address; bits [1:0] are ignored.
- `dmemstore` in DATA_W: store data.
- `dhit` out 1: one-cycle completion pulse.
- `dmemload` out DATA_W: load data, or SC result; held until the next completion.
- `dREN` out 1: memory read strobe.
- `dWEN` out 1: memory write strobe.
- `daddr` out ADDR_W: memory word address, with [1:0] = 0.
- `dstore` out DATA_W: memory write data.
- `dload` in DATA_W: memory read data, valid when `dwait`=0.
- `dwait` in 1: memory busy; 1 means the access is not yet complete.
- `snoop_inv` in 1: another agent wrote `snoop_addr` this cycle.
- `snoop_addr` in ADDR_W: snooped write address.

## Operation
- FSM states and transitions:
  - IDLE: if `dmemWEN`, go to WRITE. Otherwise, if `dmemREN`, go to READ. Write has priority when both are set. On acceptance, latch the address (with [1:0] forced to 0), the store data and `datomic` into `req_q`.
  - READ: drive `dREN`=1 and `daddr`=addr_q. On `dwait`=0, capture `dload` into `dmemload` and go to DONE.
  - WRITE: drive `dWEN`=1, `daddr`, and `dstore`=store_q. On `dwait`=0, go to DONE.
  - DONE: `dhit`=1 for exactly this cycle, then go to IDLE.
- No new request is accepted in DONE. The datapath latch advances on this edge, so IDLE sees the next request.
- In IDLE and DONE, `dREN` and `dWEN` are 0. `daddr` and `dstore` hold their last values.
- Link register: `link_valid` and `link_addr` (word address).
  - LL completion (READ→DONE with atomic_q): set `link_valid`=1 and `link_addr`=addr_q.
  - SC accepted in IDLE:
    - If `link_valid` and `link_addr`==addr and there is no same-cycle matching `snoop_inv`: go to WRITE. On completion, `dmemload`=1 and `link_valid`=0.
    - Otherwise: go straight to DONE without touching memory, with `dmemload`=0 and `link_valid`=0.
  - Clear `link_valid` on a plain write completion to `link_addr`, or on `snoop_inv` with `snoop_addr`[ADDR_W-1:2]==`link_addr`[ADDR_W-1:2], in any state.
  - Same-cycle LL set and matching snoop: the snoop wins, leaving `link_valid`=0.

## Timing
- Reset values: state=IDLE, `dhit`=0, `dmemload`=0, `dREN`=0, `dWEN`=0, `daddr`=0, `dstore`=0, `link_valid`=0, `link_addr`=0.
- Latency with N cycles of `dwait`=1: request seen in IDLE at cycle 0; READ/WRITE at cycles 1..N+1; `dhit` at cycle N+2. The minimum is 2 cycles from request to `dhit`.
- A failed SC: `dhit` at cycle 1.
- Back-to-back requests: the next request is accepted in the cycle after `dhit`.
- `dwait` is sampled only in READ/WRITE.
- Reset asserted mid-access: `dREN`/`dWEN` drop asynchronously, and no `dhit` is issued for the aborted request.
- Request inputs changing while in READ/WRITE are ignored, because `req_q` is authoritative.

## Configuration
- `DMEM_ATOMIC_EN` defined: LL/SC behaviour and the link register as above.
- `DMEM_ATOMIC_EN` undefined:
  - `datomic`, `snoop_inv` and `snoop_addr` are ignored, and no link state is built.
  - SC behaves as a plain store, and `dmemload` keeps its previous value on write completion.

## Structure
- `cpu_types_pkg` holds `word_t`, the `dmem_state_t` enum (IDLE, READ, WRITE, DONE) and a `WORD_MASK` constant for the [1:0] clear.
- Sub-module `ll_sc_link` contains the link register, match and snoop logic. It is instantiated only under `DMEM_ATOMIC_EN`.

## Test plan
- Read of 0x104 with `dload`=0xDEADBEEF and `dwait`=1 for 2 cycles: `dREN` high for 3 cycles, `daddr`=0x104, `dhit` at cycle 4, `dmemload`=0xDEADBEEF.
- Write of 0xCAFEF00D to 0x206 with `dwait`=0 immediately: `dWEN`=1 with `daddr`=0x204, `dhit` at cycle 2, then a new read accepted at cycle 3.
- LL of 0x300, then SC to 0x300: the SC writes memory and `dmemload`=1. A second SC to 0x300 fails with `dmemload`=0, no `dWEN`, and `dhit` at cycle 1.
- LL of 0x300, then `snoop_inv` with `snoop_addr`=0x302, then SC to 0x300: SC fails with `dmemload`=0.
- `dmemREN` and `dmemWEN` both set: WRITE path taken.
- `nRST` pulsed during READ: `dREN`=0 immediately, and no `dhit`.
